// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit queue for out-of-order results; optional flush port under ROB_FLUSH_EN
module reorder_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 8,
  parameter int TAG_WIDTH      = $clog2(DEPTH),
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef ROB_FLUSH_EN
  input  logic                      flush_i,
`endif
  input  logic                      alloc_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] alloc_rd_i,
  output logic                      alloc_ready_o,
  output logic [TAG_WIDTH-1:0]      alloc_tag_o,
  input  logic                      wb_valid_i,
  input  logic [TAG_WIDTH-1:0]      wb_tag_i,
  input  logic [DATA_WIDTH-1:0]     wb_data_i,
  output logic                      commit_valid_o,
  input  logic                      commit_ready_i,
  output logic [REG_ADDR_WIDTH-1:0] commit_rd_o,
  output logic [DATA_WIDTH-1:0]     commit_data_o,
  output logic [TAG_WIDTH-1:0]      commit_tag_o,
  output logic [TAG_WIDTH:0]        count_o
);
  logic [TAG_WIDTH:0]        r_head, r_tail;
  logic [DEPTH-1:0]          r_valid, r_done;
  logic [REG_ADDR_WIDTH-1:0] r_rd [DEPTH];
  logic [DATA_WIDTH-1:0]     r_data [DEPTH];
  logic [TAG_WIDTH-1:0]      w_head_idx, w_tail_idx;
  logic                      w_full, w_alloc_fire, w_wb_fire, w_commit_fire;
  // Handshakes and head view, all derived from registered state; full means same index, opposite wrap bit
  always_comb begin
    w_head_idx     = r_head[TAG_WIDTH-1:0];
    w_tail_idx     = r_tail[TAG_WIDTH-1:0];
    w_full         = (w_head_idx == w_tail_idx) && (r_head[TAG_WIDTH] != r_tail[TAG_WIDTH]);
    count_o        = r_tail - r_head;
    alloc_ready_o  = !w_full;
    alloc_tag_o    = w_tail_idx;
`ifdef ROB_FLUSH_EN
    commit_valid_o = r_valid[w_head_idx] && r_done[w_head_idx] && !flush_i;
`else
    commit_valid_o = r_valid[w_head_idx] && r_done[w_head_idx];
`endif
    commit_rd_o    = r_rd[w_head_idx];
    commit_data_o  = r_data[w_head_idx];
    commit_tag_o   = w_head_idx;
    w_alloc_fire   = alloc_valid_i && alloc_ready_o;
    w_wb_fire      = wb_valid_i && r_valid[wb_tag_i] && !r_done[wb_tag_i];
    w_commit_fire  = commit_valid_o && commit_ready_i;
  end
  // Pointers and status bits; alloc, writeback and commit never touch the same entry in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
`ifdef ROB_FLUSH_EN
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
`endif
    end else begin
      if (w_alloc_fire) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_done[w_tail_idx]  <= 1'b0;
        r_tail              <= r_tail + {{TAG_WIDTH{1'b0}}, 1'b1};
      end
      if (w_wb_fire) r_done[wb_tag_i] <= 1'b1;
      if (w_commit_fire) begin
        r_valid[w_head_idx] <= 1'b0;
        r_head              <= r_head + {{TAG_WIDTH{1'b0}}, 1'b1};
      end
    end
  end
  // Payload storage needs no reset; it is only observed behind valid/done
  always_ff @(posedge clk) begin
    if (w_alloc_fire) r_rd[w_tail_idx] <= alloc_rd_i;
    if (w_wb_fire) r_data[wb_tag_i] <= wb_data_i;
  end
endmodule
